// File: rtl/pipe_pkg.sv
// Shared definitions for the ID/EX operand-capture stage.
// Holds the default data/register-address widths, the forwarding-source
// encoding reported by fwd_select, and the hard-wired zero register number.
package pipe_pkg;

  localparam int unsigned DATA_W_DEFAULT = 32;
  localparam int unsigned REG_AW_DEFAULT = 5;

  // Register number that always reads as zero and is never a producer.
  localparam int unsigned REG_ZERO = 0;

  // Where an operand was sourced from, lowest to highest priority.
  typedef enum logic [1:0] {
    FWD_RF,
    FWD_WB,
    FWD_MEM,
    FWD_EX
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_operand_stage_fwd_select.sv
// fwd_select: combinational priority select for one source operand.
// Compile-time option: ID_EX_FWD_EN enables the EX and MEM bypass paths;
// without it only the WB bypass and regfile data are selectable.
// Ports:
//   src                         source register number
//   rf_data                     regfile read data for src
//   ex_write/ex_dest/ex_result  EX producer (ex_write already gated by ex_valid)
//   mem_write/mem_dest/mem_result  MEM producer
//   wb_write/wb_dest/wb_data    WB producer
//   sel, data                   chosen source and operand value
//   ex_hit, mem_hit             raw producer matches, used for hazard detection
module fwd_select
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned REG_AW = REG_AW_DEFAULT
) (
  input  logic [REG_AW-1:0] src,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              ex_write,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              mem_write,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_write,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  output fwd_sel_e          sel,
  output logic [DATA_W-1:0] data,
  output logic              ex_hit,
  output logic              mem_hit
);

  logic src_nz;
  logic wb_hit;

  assign src_nz  = (src != REG_AW'(REG_ZERO));
  assign ex_hit  = ex_write  & src_nz & (ex_dest  == src);
  assign mem_hit = mem_write & src_nz & (mem_dest == src);
  assign wb_hit  = wb_write  & src_nz & (wb_dest  == src);

`ifndef ID_EX_FWD_EN
  logic unused_bypass;
  assign unused_bypass = ^{ex_result, mem_result};
`endif

  // The WB path is always kept: the regfile writes at the same edge, so a
  // same-cycle read still returns the stale value.
  always_comb begin
    sel  = FWD_RF;
    data = rf_data;
    if (!src_nz) begin
      data = '0;
    end
`ifdef ID_EX_FWD_EN
    else if (ex_hit) begin
      sel  = FWD_EX;
      data = ex_result;
    end else if (mem_hit) begin
      sel  = FWD_MEM;
      data = mem_result;
    end
`endif
    else if (wb_hit) begin
      sel  = FWD_WB;
      data = wb_data;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: resolves ID-stage operands against EX/MEM/WB
// producers, detects hazards, stalls the front end and registers the
// resolved instruction into the ID/EX pipeline register.
// Compile-time option: ID_EX_FWD_EN (full EX/MEM/WB forwarding; when
// undefined any EX or MEM match stalls until the producer reaches WB).
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   id_*                            ID instruction, regfile read data, flush
//   ex_result, mem_*, wb_*          downstream producers
//   stall                           combinational front-end hold
//   ex_valid/op_a/op_b/dest/reg_write/mem_read  ID/EX register
//   stall_cycles                    saturating stall-cycle counter
module id_ex_operand_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned REG_AW = REG_AW_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic              mem_reg_write,
  input  logic [DATA_W-1:0] mem_result,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic              wb_reg_write,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_op_a,
  output logic [DATA_W-1:0] ex_op_b,
  output logic [REG_AW-1:0] ex_dest,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [31:0]       stall_cycles
);

  logic              ex_write;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  fwd_sel_e          sel_a;
  fwd_sel_e          sel_b;
  logic              ex_hit_a, ex_hit_b;
  logic              mem_hit_a, mem_hit_b;
  logic              hazard;
  logic              unused_sel;

  assign ex_write   = ex_valid & ex_reg_write;
  assign unused_sel = ^{sel_a, sel_b};

  fwd_select #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_a (
    .src       (id_rs),
    .rf_data   (id_rdata1),
    .ex_write  (ex_write),
    .ex_dest   (ex_dest),
    .ex_result (ex_result),
    .mem_write (mem_reg_write),
    .mem_dest  (mem_dest),
    .mem_result(mem_result),
    .wb_write  (wb_reg_write),
    .wb_dest   (wb_dest),
    .wb_data   (wb_data),
    .sel       (sel_a),
    .data      (op_a),
    .ex_hit    (ex_hit_a),
    .mem_hit   (mem_hit_a)
  );

  fwd_select #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_b (
    .src       (id_rt),
    .rf_data   (id_rdata2),
    .ex_write  (ex_write),
    .ex_dest   (ex_dest),
    .ex_result (ex_result),
    .mem_write (mem_reg_write),
    .mem_dest  (mem_dest),
    .mem_result(mem_result),
    .wb_write  (wb_reg_write),
    .wb_dest   (wb_dest),
    .wb_data   (wb_data),
    .sel       (sel_b),
    .data      (op_b),
    .ex_hit    (ex_hit_b),
    .mem_hit   (mem_hit_b)
  );

`ifdef ID_EX_FWD_EN
  // Only a load in EX is unresolvable: its data appears in MEM next cycle.
  logic unused_mem_hit;
  assign unused_mem_hit = mem_hit_a | mem_hit_b;
  assign hazard = id_valid & ex_valid & ex_mem_read & (ex_hit_a | ex_hit_b);
`else
  assign hazard = id_valid & (ex_hit_a | ex_hit_b | mem_hit_a | mem_hit_b);
`endif

  assign stall = hazard & ~flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid     <= 1'b0;
      ex_op_a      <= '0;
      ex_op_b      <= '0;
      ex_dest      <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      stall_cycles <= '0;
    end else begin
      if (stall && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      // Bubbles clear only control; operands/dest keep their last values.
      if (flush || stall) begin
        ex_valid     <= 1'b0;
        ex_reg_write <= 1'b0;
        ex_mem_read  <= 1'b0;
      end else begin
        ex_valid     <= id_valid;
        ex_reg_write <= id_valid & id_reg_write;
        ex_mem_read  <= id_valid & id_mem_read;
        ex_op_a      <= op_a;
        ex_op_b      <= op_b;
        ex_dest      <= id_dest;
      end
    end
  end

endmodule

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

Operand-capture stage directly downstream of the register file. Takes the two read ports plus the instruction's register fields in ID, resolves data hazards against the instructions in EX, MEM and WB, and registers the resolved operands into the ID/EX pipeline register. It also detects load-use hazards, stalls the front end, and injects bubbles. A stall-cycle counter is provided for performance bring-up.

## Interface
- DATA_W, 32, operand/data width
- REG_AW, 5, register address width; register 0 is hard-wired zero
- clk  in  1  pipeline clock; all state updates on posedge
- reset  in  1  reset, synchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  REG_AW  source register numbers, the same values driven to the regfile read addresses
- id_rdata1, id_rdata2  in  DATA_W  regfile read data for rs/rt
- id_dest  in  REG_AW  destination register of the ID instruction
- id_reg_write, id_mem_read  in  1  ID instruction writes a register / is a load
- flush  in  1  kill the ID instruction (branch taken)
- ex_result  in  DATA_W  ALU result of the instruction currently in EX
- mem_dest, mem_reg_write, mem_result  in  REG_AW/1/DATA_W  MEM-stage producer
- wb_dest, wb_reg_write, wb_data  in  REG_AW/1/DATA_W  WB-stage producer; the same values drive the regfile write port
- stall  out  1  hold PC and IF/ID this cycle
- ex_valid  out  1  registered; EX holds a real instruction
- ex_op_a, ex_op_b  out  DATA_W  registered resolved operands
- ex_dest  out  REG_AW  registered destination
- ex_reg_write, ex_mem_read  out  1  registered control
- stall_cycles  out  32  saturating count of cycles with stall=1

## Operation
- Producer match for source s: producer reg_write=1, producer dest==s, and s!=0. EX also requires ex_valid=1.
- Operand priority per source, highest first: EX match → ex_result; MEM match → mem_result; WB match → wb_data; otherwise regfile data. s==0 always yields 0.
- The WB bypass is mandatory because the regfile commits WB data at the same edge, so a same-cycle read returns the old value.
- Load-use hazard: id_valid, ex_valid, ex_mem_read, and an EX match on rs or rt. Loads in EX have no usable ex_result.
- stall = hazard & ~flush. The signal is combinational.
- Pipeline register update at each posedge, in priority order:
  - reset: all ex_* = 0, stall_cycles = 0.
  - flush: ex_valid ≤ 0, ex_reg_write ≤ 0, ex_mem_read ≤ 0 (bubble).
  - stall: bubble inserted identically; ID contents are held upstream and re-evaluated next cycle.
  - else: capture the ID instruction. Control bits are gated by id_valid.
- A bubble keeps ex_op_a, ex_op_b and ex_dest at their previous values; only the valid/control bits clear.
- stall_cycles increments on every cycle with stall=1 and holds at 0xFFFF_FFFF.

## Timing
- ID → EX latency: 1 cycle.
- stall has 0-cycle latency: it is asserted in the same cycle the hazard is present.
- Load-use costs exactly 1 stall cycle with forwarding. On the next cycle the load sits in MEM, and forwarding is from mem_result (the MEM stage presents load data in mem_result).
- flush and stall in the same cycle: flush wins, stall=0, one bubble.
- Reset asserted mid-stall: the next cycle has stall counter 0 and ex_valid 0. stall is combinational and drops as soon as ex_valid=0.
- Same register matched by both EX and WB: the EX value is used.

## Configuration
- ID_EX_FWD_EN defined: full forwarding as above.
- ID_EX_FWD_EN undefined:
  - No EX or MEM bypass.
  - hazard = any valid EX or MEM match on rs/rt, so the consumer stalls until the producer reaches WB.
  - The WB bypass remains.
  - Back-to-back dependent ALU ops cost 2 stall cycles; load-use also costs 2.

## Structure
- Package pipe_pkg holds:
  - DATA_W and REG_AW defaults
  - typedef enum fwd_sel_e {FWD_RF, FWD_WB, FWD_MEM, FWD_EX}
  - REG_ZERO constant
- One sub-module, fwd_select: a combinational priority select for a single operand, outputting fwd_sel_e and data. It is instantiated twice (rs, rt).
- The stall logic, pipeline register and counter live in the top level.

## Test plan
- Reset: hold reset 2 cycles → all ex_* = 0, stall=0, stall_cycles=0.
- EX forward:
  - Stimulus: EX writes r5 with ex_result=0x1234, ID reads rs=5 with regfile 0xAAAA.
  - Response: next cycle ex_op_a=0x1234, no stall.
- Priority and r0:
  - Stimulus: EX, MEM and WB all write r7 with 1/2/3 → ex_op_b=1.
  - Stimulus: with rs=0 and all producers on r0 → ex_op_a=0.
- Load-use:
  - Stimulus: EX load to r9, ID uses rt=9.
  - Response: stall=1 for 1 cycle, ex_valid=0 bubble, then ex_op_b=mem_result; stall_cycles=1. With the macro undefined: 2 stall cycles, stall_cycles=2.
- Flush over stall: load-use hazard with flush=1 → stall=0, ex_valid=0, stall_cycles unchanged.
- Counter saturation: preload stall_cycles=0xFFFF_FFFE via force, stall 3 cycles → counter reads 0xFFFF_FFFF.
